wash_sequencer: RTL
===================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 4: number of selectable wash programs.
REQ-002 Parameter MODE_W, default 2: mode_sel width, at least clog2(NUM_MODES).
REQ-003 Parameter TICK_DIV, default 100000000: clk cycles per timing tick.
REQ-004 Parameter BASE_T, default 8: base phase duration in ticks, range 1..127.
REQ-005 Parameter BAL_W, default 12: balance, price and fine width.
REQ-006 Parameter PAUSE_LIM, default 30: free pause ticks before fines accrue.
REQ-007 Parameter FINE_STEP, default 1: fine added per tick beyond PAUSE_LIM.
REQ-008 Ports, in this order:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle pulse, debounced upstream
- confirm  in  1  one-cycle pulse
- pause  in  1  one-cycle toggle pulse
- cancel  in  1  one-cycle pulse
- mode_sel  in  MODE_W  program index
- bal_in  in  BAL_W  signed customer balance
- price_bus  in  NUM_MODES*BAL_W  unsigned prices; mode i at bits [i*BAL_W +: BAL_W]
- state_o  out  3  current state code
- remain_o  out  8  ticks left in current phase
- water_lvl  out  8  thermometer water level
- bal_out  out  BAL_W  signed settled balance
- fine_out  out  BAL_W  accrued fine
- buzzer  out  1  alarm
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
REQ-009 Single clock domain on clk; rst is synchronous and active-low.

Function
REQ-010 State codes: IDLE=0, SELECT=1, FILL=2, WASH=3, RINSE=4, SPIN=5, PAUSE=6, BILL=7.
REQ-011 Tick generator:
- counter runs 0..TICK_DIV-1; one-cycle tick at wrap;
- counter cleared while in IDLE;
- counter free-runs in all other states, including PAUSE.
REQ-012 IDLE->SELECT on start; start is ignored in all other states.
REQ-013 SELECT, on confirm with mode_sel < NUM_MODES:
- latch mode, bal_in and the selected price;
- clear fine_out;
- go to FILL.
REQ-014 SELECT with confirm and mode_sel >= NUM_MODES: no action; state stays SELECT.
REQ-015 Phase durations in ticks, with m = latched mode:
- FILL = BASE_T;
- WASH = BASE_T*(m+1);
- RINSE = BASE_T;
- SPIN = BASE_T*(m+1);
- each saturates at 255.
REQ-016 Phase timing:
- remain_o loads the phase duration on the cycle the phase is entered;
- remain_o decrements on each tick;
- on a tick with remain_o==1, advance FILL->WASH->RINSE->SPIN->BILL;
- each phase therefore lasts exactly its duration in ticks.
REQ-017 water_lvl by state:
- FILL: on each tick shift left inserting 1, saturating at 8'hFF;
- WASH and RINSE: force 8'hFF;
- SPIN: on each tick shift right inserting 0;
- all other states except PAUSE: 0;
- PAUSE: hold.
REQ-018 Pause entry: a pause pulse in FILL..SPIN enters PAUSE, saves the return state and freezes remain_o.
REQ-019 Pause resume: a pause pulse in PAUSE returns to the saved state with remain_o unchanged.
REQ-020 PAUSE timing:
- a pause-tick counter clears on entry and increments per tick;
- on each tick once the counter exceeds PAUSE_LIM, fine_out += FINE_STEP;
- fine_out saturates at 2^BAL_W-1.
REQ-021 Cancel in FILL..SPIN or PAUSE goes to BILL next cycle, forces water_lvl to 0 and charges the full price.
REQ-022 Priority on the same cycle:
- cancel over pause;
- pause over phase completion (remain_o stays 1 and completion occurs on the first tick after resume).
REQ-023 BILL entry:
- bal_out = latched bal - price - fine_out, in BAL_W+2 signed arithmetic;
- result saturates to [-2^(BAL_W-1), 2^(BAL_W-1)-1].
REQ-024 BILL alarm: buzzer is high throughout BILL when bal_out < 0, and low otherwise.
REQ-025 BILL exit: confirm in BILL -> IDLE, done=1 for exactly one cycle, buzzer=0; bal_out and fine_out hold until the next SELECT confirm.
REQ-026 state_o, busy and remain_o are registered and reflect the current state.

Reset
REQ-027 On a clk edge with rst=0:
- state IDLE;
- remain_o, water_lvl, bal_out, fine_out = 0;
- buzzer, busy, done = 0;
- tick and pause counters = 0;
- latched mode, balance and price = 0.
REQ-028 Reset mid-operation: reset aborts any phase or PAUSE without a done pulse; the first cycle after release is IDLE.

Verification (TICK_DIV=4, BASE_T=2, PAUSE_LIM=2, NUM_MODES=3, BAL_W=12)
REQ-029 start, mode_sel=1, bal_in=100, price[1]=45, confirm -> FILL 2 ticks, WASH 4, RINSE 2, SPIN 4 (48 clk total); BILL with bal_out=55, buzzer=0; confirm -> done pulse, IDLE.
REQ-030 mode 0, bal_in=20, price[0]=45 -> BILL with bal_out=-25 and buzzer=1 until confirm, then buzzer=0.
REQ-031 pause in WASH with remain_o=3, held 5 ticks, then pause -> fine_out=3, remain_o resumes at 3, bal_out reduced by an extra 3.
REQ-032 mode_sel=3, confirm -> state_o stays 1; then mode_sel=2, confirm -> FILL.
REQ-033 cancel during RINSE -> next cycle state_o=7, water_lvl=0, full price deducted; cancel and pause on the same cycle -> BILL.
REQ-034 rst=0 for one edge mid-SPIN -> all outputs 0, state_o=0, no done pulse; a subsequent start operates normally.

Source files
------------

// File: rtl/wash_sequencer.sv
// Coin-op washing machine sequencer: program select, timed fill/wash/rinse/spin phases,
// pause with overtime fines, cancel, and signed balance settlement with an alarm.
module wash_sequencer #(
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned MODE_W    = 2,
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned BASE_T    = 8,
  parameter int unsigned BAL_W     = 12,
  parameter int unsigned PAUSE_LIM = 30,
  parameter int unsigned FINE_STEP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       confirm,
  input  logic                       pause,
  input  logic                       cancel,
  input  logic [MODE_W-1:0]          mode_sel,
  input  logic [BAL_W-1:0]           bal_in,
  input  logic [NUM_MODES*BAL_W-1:0] price_bus,
  output logic [2:0]                 state_o,
  output logic [7:0]                 remain_o,
  output logic [7:0]                 water_lvl,
  output logic [BAL_W-1:0]           bal_out,
  output logic [BAL_W-1:0]           fine_out,
  output logic                       buzzer,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PcW  = 16;
  // One guard bit beyond BAL_W+2 so the worst-case debit cannot wrap before saturation.
  localparam int unsigned AccW = BAL_W + 3;
  localparam logic signed [AccW-1:0] BalMax = AccW'((1 << (BAL_W - 1)) - 1);
  localparam logic signed [AccW-1:0] BalMin = ~BalMax;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StFill   = 3'd2,
    StWash   = 3'd3,
    StRinse  = 3'd4,
    StSpin   = 3'd5,
    StPause  = 3'd6,
    StBill   = 3'd7
  } state_e;

  state_e              state_q, state_d, ret_q, ret_d;
  logic [CntW-1:0]     tcnt_q, tcnt_d;
  logic [PcW-1:0]      pcnt_q, pcnt_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [BAL_W-1:0]    bal_q, bal_d, price_q, price_d, fine_q, fine_d;
  logic [BAL_W-1:0]    bal_out_q, bal_out_d, price_sel;
  logic [BAL_W:0]      fsum;
  logic signed [AccW-1:0] acc;
  logic [7:0]          remain_q, remain_d, water_q, water_d;
  logic                buzzer_q, buzzer_d, busy_q, busy_d, done_q, done_d;
  logic                tick, in_phase, sel_ok;

  function automatic logic [7:0] phase_dur(input state_e st, input logic [MODE_W-1:0] m);
    int unsigned d;
    d = BASE_T;
    if (st == StWash || st == StSpin) d = BASE_T * (32'(m) + 32'd1);
    return (d > 32'd255) ? 8'hFF : d[7:0];
  endfunction

  function automatic state_e next_phase(input state_e st);
    case (st)
      StFill:  return StWash;
      StWash:  return StRinse;
      StRinse: return StSpin;
      default: return StBill;
    endcase
  endfunction

  assign tick     = (state_q != StIdle) && (tcnt_q == CntW'(TICK_DIV - 1));
  assign in_phase = state_q inside {StFill, StWash, StRinse, StSpin};
  assign sel_ok   = 32'(mode_sel) < NUM_MODES;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSelect;
      StSelect: if (confirm && sel_ok) state_d = StFill;
      StFill, StWash, StRinse, StSpin: begin
        if (cancel)                         state_d = StBill;
        else if (pause)                     state_d = StPause;
        else if (tick && remain_q == 8'd1)  state_d = next_phase(state_q);
      end
      StPause: begin
        if (cancel)     state_d = StBill;
        else if (pause) state_d = ret_q;
      end
      StBill:   if (confirm) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tcnt_d    = (state_q == StIdle || tick) ? '0 : tcnt_q + CntW'(1);
    pcnt_d    = '0;
    mode_d    = mode_q;
    bal_d     = bal_q;
    price_d   = price_q;
    fine_d    = fine_q;
    ret_d     = ret_q;
    remain_d  = remain_q;
    water_d   = water_q;
    bal_out_d = bal_out_q;
    fsum      = '0;
    price_sel = '0;

    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (mode_sel == MODE_W'(i)) price_sel = price_bus[i*BAL_W +: BAL_W];
    end

    if (state_q == StSelect && state_d == StFill) begin
      mode_d  = mode_sel;
      bal_d   = bal_in;
      price_d = price_sel;
      fine_d  = '0;
    end

    if (state_q == StPause) begin
      pcnt_d = pcnt_q;
      if (tick) begin
        if (pcnt_q != '1) pcnt_d = pcnt_q + PcW'(1);
        if (32'(pcnt_q) + 32'd1 > PAUSE_LIM) begin
          fsum   = {1'b0, fine_q} + (BAL_W + 1)'(FINE_STEP);
          fine_d = fsum[BAL_W] ? '1 : fsum[BAL_W-1:0];
        end
      end
    end

    if (state_d == StPause && state_q != StPause) ret_d = state_q;

    // Phase entry loads a fresh duration; resuming from PAUSE keeps the frozen count.
    if (state_d != state_q) begin
      if (state_d inside {StFill, StWash, StRinse, StSpin}) begin
        if (state_q != StPause) remain_d = phase_dur(state_d, mode_q);
      end else if (state_d != StPause) begin
        remain_d = '0;
      end
    end else if (in_phase && tick) begin
      remain_d = remain_q - 8'd1;
    end

    case (state_d)
      StFill:  if (state_q == StFill && tick) water_d = {water_q[6:0], 1'b1};
      StWash, StRinse: water_d = 8'hFF;
      StSpin:  if (state_q == StSpin && tick) water_d = {1'b0, water_q[7:1]};
      StPause: water_d = water_q;
      default: water_d = '0;
    endcase

    acc = $signed({{3{bal_q[BAL_W-1]}}, bal_q}) - $signed({3'b000, price_q})
        - $signed({3'b000, fine_d});
    if (state_d == StBill && state_q != StBill) begin
      if (acc > BalMax)      bal_out_d = BalMax[BAL_W-1:0];
      else if (acc < BalMin) bal_out_d = BalMin[BAL_W-1:0];
      else                   bal_out_d = acc[BAL_W-1:0];
    end

    buzzer_d = (state_d == StBill) && bal_out_d[BAL_W-1];
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StBill) && (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt_q    <= '0;
      pcnt_q    <= '0;
      mode_q    <= '0;
      bal_q     <= '0;
      price_q   <= '0;
      fine_q    <= '0;
      ret_q     <= StIdle;
      remain_q  <= '0;
      water_q   <= '0;
      bal_out_q <= '0;
      buzzer_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      mode_q    <= mode_d;
      bal_q     <= bal_d;
      price_q   <= price_d;
      fine_q    <= fine_d;
      ret_q     <= ret_d;
      remain_q  <= remain_d;
      water_q   <= water_d;
      bal_out_q <= bal_out_d;
      buzzer_q  <= buzzer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign state_o   = state_q;
  assign remain_o  = remain_q;
  assign water_lvl = water_q;
  assign bal_out   = bal_out_q;
  assign fine_out  = fine_q;
  assign buzzer    = buzzer_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
